// File: rtl/alu_operand_sequencer_pkg.sv
// alu_operand_sequencer_pkg: opcodes, flag indices and FSM encoding shared by the sequencer and its logic bank.
package alu_operand_sequencer_pkg;
  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NAND = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_ADD  = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_CLR  = 4'd11;
  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_ERR   = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/alu_operand_sequencer_logic_bank.sv
// alu_logic_bank: combinational gate units and adder, muxed by opcode, with raw carry/overflow.
module alu_logic_bank
  import alu_operand_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);
  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  assign sub   = op == OP_SUB;
  assign b_eff = sub ? ~b : b;
  // subtraction reuses the adder as a + ~b + 1, so carry is the inverted borrow
  assign sum   = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 1)'(sub);
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_PASS: result = b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_NOT:  result = ~a;
      OP_ADD, OP_SUB: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: handshake-driven IDLE/EXEC/DONE sequencer feeding the logic bank into a flagged accumulator.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d, res;
  logic [OPW-1:0]   op_q, op_d;
  logic [3:0]       flags_q, flags_d;
  logic             carry, ovf, illegal;
  alu_logic_bank #(.WIDTH(WIDTH), .OPW(OPW)) u_bank (
    .op(op_q), .a(opa_q), .b(opb_q), .result(res), .carry(carry), .ovf(ovf)
  );
  assign illegal    = op_q > OPW'(OP_CLR);
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign out_result = acc_q;
  assign out_flags  = flags_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    case (state_q)
      IDLE: if (in_valid) begin
        opa_d   = in_use_acc ? acc_q : in_a;
        opb_d   = in_b;
        op_d    = in_op;
        state_d = EXEC;
      end
      EXEC: begin
        // an illegal opcode leaves the accumulator untouched and only raises err
        acc_d   = illegal ? acc_q : res;
        flags_d = illegal ? {1'b1, 2'b00, acc_q == '0} : {1'b0, ovf, carry, res == '0};
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      flags_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
    end
  end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: scoreboard bench with an independent integer reference model of the sequencer.
module tb_alu_operand_sequencer;
  typedef struct packed {logic [3:0] f; logic [15:0] r;} exp_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_use_acc = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_op = '0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  exp_t        sb_q[$];
  logic [15:0] m_acc = '0;
  int          n_pass = 0, n_total = 0;
  alu_operand_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] acc_prev);
    exp_t e;
    int   sa, sb, s;
    sa  = $signed(a);
    sb  = $signed(b);
    e.f = 4'b0000;
    e.r = 16'h0000;
    case (op)
      4'd0: e.r = b;
      4'd1: e.r = a & b;
      4'd2: e.r = a | b;
      4'd3: e.r = a ^ b;
      4'd4: e.r = ~(a & b);
      4'd5: e.r = ~(a | b);
      4'd6: e.r = ~a;
      4'd7: begin
        e.r = a + b;
        e.f[1] = (int'(a) + int'(b)) > 65535;
        s = sa + sb;
        e.f[2] = (s > 32767) || (s < -32768);
      end
      4'd8: begin
        e.r = a - b;
        e.f[1] = a >= b;
        s = sa - sb;
        e.f[2] = (s > 32767) || (s < -32768);
      end
      4'd9:  begin e.r = a << 1; e.f[1] = a[15]; end
      4'd10: begin e.r = a >> 1; e.f[1] = a[0]; end
      4'd11: e.r = 16'h0000;
      default: begin e.r = acc_prev; e.f[3] = 1'b1; end
    endcase
    e.f[0] = e.r == 16'h0000;
    return e;
  endfunction
  // drive one request, then check latency, result and flags, optionally backpressuring for `hold` cycles
  task automatic txn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic ua, input int hold);
    exp_t e, got;
    int   cnt;
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 20) begin @(negedge clk); cnt++; end
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    e = model(op, ua ? m_acc : a, b, m_acc);
    sb_q.push_back(e);
    m_acc = e.r;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_use_acc = ua;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!out_valid && cnt < 10);
    chk("latency", cnt, 32'd2);
    got = exp_t'({out_flags, out_result});
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk($sformatf("result_op%0d", op), {16'b0, got.r}, {16'b0, e.r});
      chk($sformatf("flags_op%0d", op), {28'b0, got.f}, {28'b0, e.f});
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; in_op = 4'd11; in_a = 16'hDEAD; in_use_acc = 1'b0;
      @(negedge clk);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_result", {16'b0, out_result}, {16'b0, got.r});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_ready", {31'b0, in_ready}, 32'd1);
    chk("idle_valid", {31'b0, out_valid}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", {16'b0, out_result}, 32'd0);
    chk("rst_flags", {28'b0, out_flags}, 32'd0);
    txn(4'd4, 16'h00FF, 16'hFF55, 1'b0, 0);
    chk("nand_const", {16'b0, out_result}, 32'h0000FFAA);
    txn(4'd7, 16'hFFFF, 16'h0001, 1'b0, 0);
    chk("add_wrap_flags", {28'b0, out_flags}, 32'b0011);
    txn(4'd8, 16'h8000, 16'h0001, 1'b0, 0);
    chk("sub_const", {12'b0, out_flags, out_result}, {12'b0, 4'b0110, 16'h7FFF});
    txn(4'd0, 16'h0000, 16'h1234, 1'b0, 0);
    txn(4'd3, 16'hBEEF, 16'h1234, 1'b1, 0);
    chk("xor_acc_zero", {12'b0, out_flags, out_result}, {12'b0, 4'b0001, 16'h0000});
    txn(4'd6, 16'h0F0F, 16'h0000, 1'b1, 0);
    chk("not_acc", {16'b0, out_result}, 32'h0000FFFF);
    txn(4'd2, 16'h1200, 16'h0034, 1'b0, 5);
    txn(4'd0, 16'h0000, 16'h00A5, 1'b0, 0);
    txn(4'd13, 16'h1111, 16'h2222, 1'b0, 0);
    chk("illegal_const", {12'b0, out_flags, out_result}, {12'b0, 4'b1000, 16'h00A5});
    txn(4'd10, 16'h0000, 16'h0000, 1'b1, 0);
    chk("shr_const", {12'b0, out_flags, out_result}, {12'b0, 4'b0010, 16'h0052});
    for (int i = 0; i < 20; i++)
      txn(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0);
    txn(4'd0, 16'h0000, 16'h5A5A, 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd7; in_a = 16'h0001; in_b = 16'h0001; in_use_acc = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_result", {16'b0, out_result}, 32'd0);
    chk("arst_flags", {28'b0, out_flags}, 32'd0);
    sb_q.delete();
    m_acc = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    txn(4'd7, 16'h0003, 16'h0004, 1'b0, 0);
    chk("add_after_rst", {16'b0, out_result}, 32'h00000007);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
